// File: rtl/fifo_uart_pkg.sv
// Shared types and sizing helpers for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int DEF_STOP_BITS    = 1;

  // Cycle counter must reach CLKS_PER_BIT*STOP_BITS-1 (longest timed span).
  function automatic int clk_cnt_w(input int cpb, input int sb);
    int w;
    w = $clog2(cpb * sb);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int bit_cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

  // Line cycles from the falling start edge to the end of the last stop bit.
  function automatic int frame_len(input int dw, input int cpb, input int sb);
    return (1 + dw + sb) * cpb;
  endfunction

  localparam int FRAME_LEN = frame_len(DEF_DATA_WIDTH, DEF_CLKS_PER_BIT, DEF_STOP_BITS);

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..tc_i and flags the terminal cycle.
module uart_bit_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             bit_done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Terminal compare only; the counter never wraps past tc_i.
  assign bit_done_o = (cnt_q == tc_i);

  // Restart at zero on load or at the terminal cycle, otherwise count up.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (load_i || bit_done_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a show-ahead FIFO and serialises them as UART frames
// (start bit, LSB-first data, stop bits) with no gap between frames.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS    = DEF_STOP_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_val,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a word is consumed on a rising edge where rd_en && rd_val;
  // rd_en only rises when the FIFO already shows valid data, so a pop never
  // hits an empty FIFO and rd_en is forced low while reset is asserted.

  localparam int CNT_W = clk_cnt_w(CLKS_PER_BIT, STOP_BITS);
  localparam int BCW   = bit_cnt_w(DATA_WIDTH);

  localparam logic [CNT_W-1:0] TC_BIT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] TC_STOP  = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [BCW-1:0]   LAST_BIT = BCW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  bit_done;
  logic                  pop;
  logic [CNT_W-1:0]      tc;

  // Stop phase is timed as one long span; all other phases per bit.
  assign tc = (state_q == STOP) ? TC_STOP : TC_BIT;

  uart_bit_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q == IDLE),
    .tc_i       (tc),
    .bit_done_o (bit_done)
  );

  // Pop when idle or on the final stop cycle, so frames chain with no gap.
  assign pop = reset && rd_val &&
               ((state_q == IDLE) || ((state_q == STOP) && bit_done));

  assign rd_en       = pop;
  assign tx          = tx_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

  // Next-state, shift register and registered line value.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_d[0];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // A pop overrides everything: latch the word and drop into the start bit.
    if (pop) begin
      state_d   = START;
      shift_d   = rd_data;
      bit_cnt_d = '0;
      tx_d      = 1'b0;
    end
  end

  // State registers; reset drives the line idle-high immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a behavioural show-ahead FIFO feeds two
// instances (1 and 2 stop bits); line waveforms are captured per frame.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  logic       clk;
  logic       reset;
  logic       rd_val, rd_val2;
  logic [7:0] rd_data, rd_data2;
  logic       rd_en, rd_en2;
  logic       tx, tx2;
  logic       busy, busy2;
  logic [1:0] dbg_state, dbg_state2;

  int         n_checks;
  int         n_errors;
  int         cyc;
  logic [7:0] fq1[$];
  logic [7:0] fq2[$];
  logic [7:0] exp_q[$];
  int         pop_cyc[$];
  int         n_pop2;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .rd_val(rd_val), .rd_data(rd_data),
    .rd_en(rd_en), .tx(tx), .busy(busy), .dbg_state_o(dbg_state)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .rd_val(rd_val2), .rd_data(rd_data2),
    .rd_en(rd_en2), .tx(tx2), .busy(busy2), .dbg_state_o(dbg_state2)
  );

  // Clock and reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Show-ahead FIFO outputs follow the queue heads.
  task automatic refresh();
    rd_val   = (fq1.size() != 0);
    rd_data  = rd_val ? fq1[0] : 8'h00;
    rd_val2  = (fq2.size() != 0);
    rd_data2 = rd_val2 ? fq2[0] : 8'h00;
  endtask

  task automatic push1(input logic [7:0] b);
    fq1.push_back(b);
    exp_q.push_back(b);
    refresh();
  endtask

  // One clock: sample pops at the edge, apply them just after, end at negedge.
  task automatic step();
    logic       p1, p2;
    logic [7:0] tmp;
    @(posedge clk);
    cyc++;
    p1 = rd_en && rd_val;
    p2 = rd_en2 && rd_val2;
    #1;
    if (p1) begin
      tmp = fq1.pop_front();
      pop_cyc.push_back(cyc);
    end
    if (p2) begin
      tmp = fq2.pop_front();
      n_pop2++;
    end
    refresh();
    @(negedge clk);
  endtask

  // Line waveform of one 1-stop-bit frame: bit k is tx during cycle k.
  function automatic logic [63:0] exp_frame(input logic [7:0] b);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[4 + 4*i +: 4] = {4{b[i]}};
    v[36 +: 4] = 4'hF;
    return v;
  endfunction

  // Called on cycle 0 of a frame; returns on cycle 0 of whatever follows.
  task automatic check_frame(input int sel, input int len, input logic [63:0] expv,
                             input string tag);
    logic [63:0] obs;
    logic        all_busy;
    obs      = '0;
    all_busy = 1'b1;
    for (int k = 0; k < len; k++) begin
      obs[k]   = (sel != 0) ? tx2 : tx;
      all_busy = all_busy & ((sel != 0) ? busy2 : busy);
      step();
    end
    chkv(tag, obs, expv);
    chk1({tag, "_busy"}, all_busy, 1'b1);
  endtask

  // Scoreboard and directed sequence.
  initial begin
    logic [7:0] b;
    logic       seen;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    n_pop2   = 0;
    reset    = 1'b0;
    refresh();
    @(negedge clk);

    // 1. Held in reset, FIFO empty.
    for (int i = 0; i < 10; i++) begin
      chk1("rst_tx", tx, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_rd_en", rd_en, 1'b0);
      step();
    end
    chk1("rst_tx2", tx2, 1'b1);

    // 2. Single 8'hA5 frame.
    push1(8'hA5);
    #1;
    chk1("rd_en_gated_in_reset", rd_en, 1'b0);
    reset = 1'b1;
    #1;
    chk1("rd_en_idle_valid", rd_en, 1'b1);
    step();
    chki("a5_pops", pop_cyc.size(), 1);
    chk1("a5_start_edge", tx, 1'b0);
    b = exp_q.pop_front();
    chkv("a5_sb_byte", 64'(b), 64'h0A5);
    check_frame(0, FRAME_LEN, 64'h00FF0F00F0F0, "a5_frame");
    chk1("a5_busy_after", busy, 1'b0);
    chk1("a5_tx_after", tx, 1'b1);
    chk1("a5_rd_en_after", rd_en, 1'b0);
    chki("a5_state_after", int'(dbg_state), int'(IDLE));
    chki("a5_single_pop", pop_cyc.size(), 1);

    // 3. Four back-to-back frames from a full FIFO.
    pop_cyc.delete();
    for (int i = 0; i < 4; i++) push1(8'(i));
    step();
    for (int i = 0; i < 4; i++) begin
      b = exp_q.pop_front();
      check_frame(0, 40, exp_frame(b), $sformatf("b2b_frame%0d", i));
    end
    chki("b2b_pops", pop_cyc.size(), 4);
    for (int i = 0; i < 3; i++) begin
      chki($sformatf("b2b_gap%0d", i), pop_cyc[i+1] - pop_cyc[i], 40);
    end
    chki("b2b_fifo_empty", fq1.size(), 0);
    chk1("b2b_busy_after", busy, 1'b0);

    // 4. Reset in the middle of data bit 3 of an 8'hFF frame.
    pop_cyc.delete();
    push1(8'hFF);
    push1(8'h11);
    push1(8'h22);
    step();
    for (int i = 0; i < 18; i++) step();
    chki("mid_state_data", int'(dbg_state), int'(DATA));
    chk1("mid_busy", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk1("async_rst_tx", tx, 1'b1);
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_rd_en", rd_en, 1'b0);
    chki("async_rst_state", int'(dbg_state), int'(IDLE));
    for (int i = 0; i < 3; i++) step();
    chki("rst_fifo_kept", fq1.size(), 2);
    chki("rst_no_pop", pop_cyc.size(), 1);
    b = exp_q.pop_front();
    reset = 1'b1;
    step();
    chk1("first_pop_after_release", tx, 1'b0);
    chki("release_pops", pop_cyc.size(), 2);
    b = exp_q.pop_front();
    check_frame(0, 40, exp_frame(b), "after_rst_frame0");
    b = exp_q.pop_front();
    check_frame(0, 40, exp_frame(b), "after_rst_frame1");
    chk1("after_rst_idle", busy, 1'b0);

    // 5a. No data: no pops, line idle.
    pop_cyc.delete();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen = seen | rd_en | ~tx;
      step();
    end
    chk1("empty_quiet", seen, 1'b0);
    chki("empty_no_pop", pop_cyc.size(), 0);

    // 5b. rd_val appears only on the last stop cycle.
    push1(8'h3C);
    step();
    b = exp_q.pop_front();
    seen = 1'b0;
    for (int i = 0; i < 39; i++) begin
      seen = seen | rd_en;
      step();
    end
    chk1("late_no_early_pop", seen, 1'b0);
    chk1("late_last_stop_tx", tx, 1'b1);
    chk1("late_last_stop_busy", busy, 1'b1);
    push1(8'h5A);
    #1;
    chk1("late_rd_en", rd_en, 1'b1);
    step();
    chki("late_gap", pop_cyc[1] - pop_cyc[0], 40);
    chk1("late_start", tx, 1'b0);
    b = exp_q.pop_front();
    check_frame(0, 40, exp_frame(b), "late_frame");

    // 6. Two stop bits: 8'h00 frame is 44 cycles.
    fq2.push_back(8'h00);
    refresh();
    step();
    chki("sb2_pops", n_pop2, 1);
    check_frame(1, 44, 64'h0FF000000000, "sb2_frame");
    chk1("sb2_busy_after", busy2, 1'b0);
    chk1("sb2_tx_after", tx2, 1'b1);

    chki("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
